// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and types, common to the 4-slot demultiplexer
// and its companion transmitter.
package tdm_pkg;

    localparam int TDM_NUM_CH     = 4;
    localparam int TDM_SLOT_W     = 8;
    localparam int TDM_BIT_CNT_W  = 3;
    localparam int TDM_SLOT_CNT_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    typedef logic [TDM_BIT_CNT_W-1:0]  bit_cnt_t;
    typedef logic [TDM_SLOT_CNT_W-1:0] slot_cnt_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-within-slot and slot-within-frame counters for a 4x8 TDM frame.
// The bit counter holds the number of bits already received in the current slot.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      advance,
    input  logic      restart,
    input  logic      clear,
    output slot_cnt_t slot_cnt,
    output logic      boundary,
    output logic      word_done,
    output logic      frame_done
);

    bit_cnt_t bit_cnt;

    // restart loads the state "one bit of slot 0 already taken"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else if (clear) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else if (restart) begin
            bit_cnt  <= bit_cnt_t'(1);
            slot_cnt <= '0;
        end else if (advance) begin
            bit_cnt <= bit_cnt + bit_cnt_t'(1);
            if (bit_cnt == '1) begin
                slot_cnt <= slot_cnt + slot_cnt_t'(1);
            end
        end
    end

    assign boundary   = (bit_cnt == '0) && (slot_cnt == '0);
    assign word_done  = (bit_cnt == '1);
    assign frame_done = (bit_cnt == '1) && (slot_cnt == '1);

endmodule

// File: rtl/tdm_demux4.sv
// Serial 4-slot TDM frame demultiplexer: locks on sync, shifts slots MSB-first,
// stages completed words and publishes whole frames atomically.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int NUM_CH = TDM_NUM_CH,
    parameter int SLOT_W = TDM_SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              din,
    output logic [SLOT_W-1:0] out0,
    output logic [SLOT_W-1:0] out1,
    output logic [SLOT_W-1:0] out2,
    output logic [SLOT_W-1:0] out3,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              locked
);

    // en is a qualifier, not a handshake: a cycle with en=0 is invisible to
    // all state, and every en=1 cycle carries exactly one bit (and its sync).

    tdm_state_e        state_q, state_d;
    logic [SLOT_W-1:0] shift_q;
    logic [SLOT_W-1:0] stage_q [NUM_CH-1];
    logic [SLOT_W-1:0] new_word;

    slot_cnt_t slot_cnt;
    logic      boundary, word_done, frame_done;
    logic      cnt_adv, cnt_restart, cnt_clear;
    logic      shift_load, shift_en, clear_stage, err_d;
    logic      frame_done_now;

    tdm_slot_counter u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (cnt_adv),
        .restart    (cnt_restart),
        .clear      (cnt_clear),
        .slot_cnt   (slot_cnt),
        .boundary   (boundary),
        .word_done  (word_done),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_adv     = 1'b0;
        cnt_restart = 1'b0;
        cnt_clear   = 1'b0;
        shift_load  = 1'b0;
        shift_en    = 1'b0;
        clear_stage = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (en && sync) begin
                    state_d     = ST_LOCKED;
                    cnt_restart = 1'b1;
                    shift_load  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (en) begin
                    if (sync && !boundary) begin
                        // early sync: drop the partial frame, this bit opens a new one
                        err_d       = 1'b1;
                        cnt_restart = 1'b1;
                        shift_load  = 1'b1;
                        clear_stage = 1'b1;
                    end else if (!sync && boundary) begin
                        err_d     = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        cnt_adv  = 1'b1;
                        shift_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    assign new_word       = {shift_q[SLOT_W-2:0], din};
    assign frame_done_now = shift_en && frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            for (int i = 0; i < NUM_CH-1; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            frame_valid <= frame_done_now;
            sync_err    <= err_d;

            if (shift_load) begin
                shift_q <= {{(SLOT_W-1){1'b0}}, din};
            end else if (shift_en) begin
                shift_q <= new_word;
            end

            // the last slot bypasses staging and goes straight to out3
            if (clear_stage) begin
                for (int i = 0; i < NUM_CH-1; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (shift_en && word_done) begin
                for (int i = 0; i < NUM_CH-1; i++) begin
                    if (slot_cnt == slot_cnt_t'(i)) begin
                        stage_q[i] <= new_word;
                    end
                end
            end

            if (frame_done_now) begin
                out0 <= stage_q[0];
                out1 <= stage_q[1];
                out2 <= stage_q[2];
                out3 <= new_word;
            end
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule
